// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the sequential ALU.
// Flag positions match the existing {N,Z,C,V} ALUFlags bus.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_ORR  = 3'b011;
   localparam logic [2:0] OP_EOR  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_UDIV = 3'b110;
   localparam logic [2:0] OP_UREM = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
// res_acc/res_quo expose the value each register takes at the coming edge.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res_acc,
   output logic [WIDTH-1:0] res_quo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [CNT_W-1:0] cnt;
   logic             div_mode;
   logic             active;
   logic [WIDTH-1:0] x, y, acc;
   logic [WIDTH-1:0] x_nxt, y_nxt, acc_nxt;
   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] diff;
   logic             qbit;

   assign active  = (cnt != '0);
   assign last    = (cnt == CNT_W'(1));
   assign res_acc = acc_nxt;
   assign res_quo = x_nxt;

   // MUL: x = multiplicand, y = multiplier, acc = partial product.
   // DIV: x = dividend shifting out / quotient shifting in, y = divisor, acc = remainder.
   always_comb begin
      sh      = {acc, x[WIDTH-1]};
      diff    = {1'b0, sh} - {2'b00, y};
      qbit    = ~diff[WIDTH+1];
      x_nxt   = x << 1;
      y_nxt   = y >> 1;
      acc_nxt = acc + (y[0] ? x : '0);
      if (div_mode) begin
         x_nxt   = {x[WIDTH-2:0], qbit};
         y_nxt   = y;
         acc_nxt = qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         cnt      <= CNT_W'(WIDTH);
         div_mode <= is_div;
      end else if (active) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         x   <= a;
         y   <= b;
         acc <= '0;
      end else if (active) begin
         x   <= x_nxt;
         y   <= y_nxt;
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/UDIV/UREM
// behind a start/busy/done handshake; Result and {N,Z,C,V} flags are registered.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ALUControl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ALUFlags
);

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic             accept, iter_op, load, upd;
   logic             last;
   logic [WIDTH-1:0] res_acc, res_quo;
   logic [WIDTH-1:0] bx, res_nxt;
   logic [WIDTH:0]   sum;
   logic             c_nxt, v_nxt;

   function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_Z] = (r == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   assign busy    = (state == S_RUN);
   assign done    = (state == S_DONE);
   assign iter_op = (ALUControl >= OP_MUL);
   assign accept  = start && (state != S_RUN);
   assign load    = accept && iter_op;

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .is_div  (ALUControl[1]),
      .a       (a),
      .b       (b),
      .last    (last),
      .res_acc (res_acc),
      .res_quo (res_quo)
   );

   // SUB reuses the adder as a + ~b + 1, so C=1 means no borrow.
   always_comb begin
      bx      = (ALUControl == OP_SUB) ? ~b : b;
      sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (ALUControl == OP_SUB)};
      res_nxt = '0;
      c_nxt   = 1'b0;
      v_nxt   = 1'b0;
      if (state == S_RUN) begin
         case (op_q)
            OP_MUL:  res_nxt = res_acc;
            OP_UDIV: res_nxt = res_quo;
            OP_UREM: res_nxt = res_acc;
            default: res_nxt = '0;
         endcase
      end else begin
         case (ALUControl)
            OP_ADD, OP_SUB: begin
               res_nxt = sum[WIDTH-1:0];
               c_nxt   = sum[WIDTH];
               v_nxt   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_nxt = a & b;
            OP_ORR:  res_nxt = a | b;
            OP_EOR:  res_nxt = a ^ b;
            default: res_nxt = '0;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      upd       = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = iter_op ? S_RUN : S_DONE;
               upd       = !iter_op;
            end else if (state == S_DONE) begin
               state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (last) begin
               state_nxt = S_DONE;
               upd       = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         op_q     <= OP_ADD;
         Result   <= '0;
         ALUFlags <= '0;
      end else begin
         state <= state_nxt;
         if (accept) op_q <= ALUControl;
         if (upd) begin
            Result   <= res_nxt;
            ALUFlags <= make_flags(res_nxt, c_nxt, v_nxt);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=32) with hand-computed expected values.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a, b;
   logic [2:0]  ALUControl;
   logic        busy, done;
   logic [31:0] Result;
   logic [3:0]  ALUFlags;

   int n_chk  = 0;
   int n_fail = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .busy       (busy),
      .done       (done),
      .Result     (Result),
      .ALUFlags   (ALUFlags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at #1 after an edge; returns at #1 after the edge where done is seen.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_r, input logic [3:0] exp_f,
                         input int exp_lat);
      int lat;
      int busy_cnt;
      busy_cnt   = 0;
      start      = 1'b1;
      ALUControl = op;
      a          = av;
      b          = bv;
      @(posedge clk); #1;
      start      = 1'b0;
      a          = ~av;
      b          = ~bv;
      ALUControl = ~op;
      lat        = 1;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
      check({tag, " Result"}, 64'(Result), 64'(exp_r));
      check({tag, " ALUFlags"}, 64'(ALUFlags), 64'(exp_f));
   endtask

   initial begin
      int dones;
      int first_done;
      reset      = 1'b1;
      start      = 1'b0;
      a          = '0;
      b          = '0;
      ALUControl = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset Result", 64'(Result), 64'(0));
      check("reset ALUFlags", 64'(ALUFlags), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      run_op("add ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1);
      run_op("add carry", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1);
      run_op("sub 5-5",   OP_SUB,  32'd5,         32'd5,         32'h0000_0000, 4'b0110, 1);
      run_op("sub 3-5",   OP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000, 1);
      run_op("eor",       OP_EOR,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0000, 1);
      run_op("orr",       OP_ORR,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'hFFFF_F0F0, 4'b1000, 1);
      run_op("and",       OP_AND,  32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000, 4'b1000, 1);
      run_op("mul wrap",  OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0100, 33);
      run_op("mul",       OP_MUL,  32'd1234,      32'd5678,      32'd7006652,   4'b0000, 33);
      run_op("b2b add",   OP_ADD,  32'd2,         32'd3,         32'd5,         4'b0000, 1);
      run_op("udiv",      OP_UDIV, 32'd100,       32'd7,         32'd14,        4'b0000, 33);
      run_op("urem",      OP_UREM, 32'd100,       32'd7,         32'd2,         4'b0000, 33);
      run_op("udiv /0",   OP_UDIV, 32'd9,         32'd0,         32'hFFFF_FFFF, 4'b1000, 33);
      run_op("urem /0",   OP_UREM, 32'd9,         32'd0,         32'd9,         4'b0000, 33);

      // MUL 3*4 started at cycle 0, extra ADD starts at cycles 5 and 10 must be dropped
      start      = 1'b1;
      ALUControl = OP_MUL;
      a          = 32'd3;
      b          = 32'd4;
      @(posedge clk); #1;
      start      = 1'b0;
      dones      = 0;
      first_done = 0;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            dones++;
            if (first_done == 0) first_done = c;
         end
         start      = (c == 5 || c == 10);
         ALUControl = OP_ADD;
         a          = 32'd1;
         b          = 32'd1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("ignore done count", 64'(dones), 64'(1));
      check("ignore done cycle", 64'(first_done), 64'(33));
      check("ignore Result", 64'(Result), 64'(12));

      // reset at cycle 10 of a UDIV aborts it
      start      = 1'b1;
      ALUControl = OP_UDIV;
      a          = 32'd100;
      b          = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      check("mid-run busy", 64'(busy), 64'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      check("abort Result", 64'(Result), 64'(0));
      check("abort ALUFlags", 64'(ALUFlags), 64'(0));
      run_op("add after rst", OP_ADD, 32'd2, 32'd2, 32'd4, 4'b0000, 1);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort no ghost done", 64'(dones), 64'(0));

      // reset and start together: start is dropped
      reset      = 1'b1;
      start      = 1'b1;
      ALUControl = OP_ADD;
      a          = 32'd7;
      b          = 32'd7;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      check("rst+start done", 64'(done), 64'(0));
      check("rst+start Result", 64'(Result), 64'(0));
      @(posedge clk); #1;
      check("rst+start later done", 64'(done), 64'(0));
      check("rst+start idle Result", 64'(Result), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
